// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory opcodes, op decode and stage bundles.
package cpu_pkg;

    localparam int DM_WORDS_DEFAULT = 4096;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [3:0] {
        NONE, LW, LH, LHU, LB, LBU, SW, SH, SB
    } mem_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  a3;
        logic [31:0] wd;
    } mem_wb_t;

    function automatic mem_op_t decode_op(input logic [5:0] op);
        mem_op_t m;
        m = NONE;
        unique case (1'b1)
            (op == OP_LW):  m = LW;
            (op == OP_LH):  m = LH;
            (op == OP_LHU): m = LHU;
            (op == OP_LB):  m = LB;
            (op == OP_LBU): m = LBU;
            (op == OP_SW):  m = SW;
            (op == OP_SH):  m = SH;
            (op == OP_SB):  m = SB;
            default:        m = NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_mem.sv
// Word-organised data memory: byte-enable synchronous write, async read.
module data_mem #(
    parameter int WORDS = 4096,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    // Array starts at zero and is deliberately untouched by reset.
    logic [31:0] mem [WORDS] = '{default: '0};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB register; DM_WRITE_LOG_EN enables the store log.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCM,
    input  logic [31:0] InstrM,
    input  logic [4:0]  A3M,
    input  logic [31:0] WDM,
    input  logic [31:0] ResM,
    input  logic [31:0] RD2M,
    output logic [31:0] PCW,
    output logic [31:0] InstrW,
    output logic [4:0]  A3W,
    output logic [31:0] WDW
);

    localparam int AW = $clog2(DM_WORDS);

    mem_op_t     op;
    logic [1:0]  lane;
    logic [3:0]  be;
    logic [3:0]  be_q;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] ld_val;
    logic        is_load;
    mem_wb_t     wb;

    assign op   = decode_op(InstrM[31:26]);
    assign lane = ResM[1:0];

    always_comb begin
        be    = 4'b0000;
        wdata = RD2M;
        unique case (op)
            SW: be = 4'b1111;
            SH: begin
                be    = ResM[1] ? 4'b1100 : 4'b0011;
                wdata = {2{RD2M[15:0]}};
            end
            SB: begin
                be    = 4'b0001 << lane;
                wdata = {4{RD2M[7:0]}};
            end
            default: ;
        endcase
    end

    // A store sampled with reset high must not reach the array.
    assign be_q = be & {4{~reset}};

    data_mem #(.WORDS(DM_WORDS)) u_dm (
        .clk   (clk),
        .be    (be_q),
        .addr  (ResM[AW+1:2]),
        .wdata (wdata),
        .rdata (rdata)
    );

    assign rbyte = rdata[{lane, 3'b000} +: 8];
    assign rhalf = ResM[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ld_val  = rdata;
        is_load = 1'b1;
        unique case (op)
            LW:  ld_val = rdata;
            LH:  ld_val = {{16{rhalf[15]}}, rhalf};
            LHU: ld_val = {16'h0000, rhalf};
            LB:  ld_val = {{24{rbyte[7]}}, rbyte};
            LBU: ld_val = {24'h000000, rbyte};
            default: is_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb <= '0;
        end else begin
            wb.pc    <= PCM;
            wb.instr <= InstrM;
            wb.a3    <= A3M;
            wb.wd    <= is_load ? ld_val : WDM;
        end
    end

    assign PCW    = wb.pc;
    assign InstrW = wb.instr;
    assign A3W    = wb.a3;
    assign WDW    = wb.wd;

    logic unused_res;
    assign unused_res = ^ResM[31:AW+2];

`ifdef DM_WRITE_LOG_EN
    logic [31:0] merged;
    always_comb begin
        merged = rdata;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && |be) begin
            $display("@%h: *%h <= %h", PCM, ResM & 32'hfffffffc, merged);
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCM, InstrM, WDM, ResM, RD2M;
    logic [4:0]  A3M;
    logic [31:0] PCW, InstrW, WDW;
    logic [4:0]  A3W;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk    (clk),
        .reset  (reset),
        .PCM    (PCM),
        .InstrM (InstrM),
        .A3M    (A3M),
        .WDM    (WDM),
        .ResM   (ResM),
        .RD2M   (RD2M),
        .PCW    (PCW),
        .InstrW (InstrW),
        .A3W    (A3W),
        .WDW    (WDW)
    );

    // Present one instruction for one cycle; return #1 after the edge.
    task automatic present(input logic [5:0] op, input logic [31:0] pc,
                           input logic [4:0] a3, input logic [31:0] wd,
                           input logic [31:0] res, input logic [31:0] rd2);
        InstrM = {op, 26'h0123456};
        PCM    = pc;
        A3M    = a3;
        WDM    = wd;
        ResM   = res;
        RD2M   = rd2;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        present(6'b000000, 32'h0000_3000, 5'd9, 32'hCAFE_F00D, 0, 0);
        total++;
        if (WDW !== 32'hCAFE_F00D) begin
            $display("FAIL pre_reset WDW got %h want cafef00d", WDW);
        end else passed++;
        #2 reset = 1'b1;
        #1;
        total++;
        if (PCW !== 32'h0 || InstrW !== 32'h0 || A3W !== 5'h0 || WDW !== 32'h0) begin
            $display("FAIL async_reset got pc=%h in=%h a3=%h wd=%h want 0",
                     PCW, InstrW, A3W, WDW);
        end else passed++;
        reset = 1'b0;
    endtask

    task automatic test_store_load_word();
        present(6'b101011, 32'h0000_3004, 5'd0, 32'h0, 32'h10, 32'h1234_5678);
        present(6'b100011, 32'h0000_3008, 5'd4, 32'hDEAD_0000, 32'h10, 32'h0);
        total++;
        if (WDW !== 32'h1234_5678) begin
            $display("FAIL lw_after_sw WDW got %h want 12345678", WDW);
        end else passed++;
        total++;
        if (A3W !== 5'd4 || PCW !== 32'h0000_3008) begin
            $display("FAIL lw_regs got a3=%h pc=%h want 04 00003008", A3W, PCW);
        end else passed++;
    endtask

    task automatic test_byte_half_merge();
        present(6'b101000, 32'h0000_300c, 5'd0, 32'h0, 32'h13, 32'h5555_55AB);
        present(6'b100011, 32'h0000_3010, 5'd2, 32'h0, 32'h10, 32'h0);
        total++;
        if (WDW !== 32'hAB34_5678) begin
            $display("FAIL sb_merge WDW got %h want ab345678", WDW);
        end else passed++;
        present(6'b101001, 32'h0000_3014, 5'd0, 32'h0, 32'h10, 32'h7777_BEEF);
        present(6'b100011, 32'h0000_3018, 5'd2, 32'h0, 32'h10, 32'h0);
        total++;
        if (WDW !== 32'hAB34_BEEF) begin
            $display("FAIL sh_merge WDW got %h want ab34beef", WDW);
        end else passed++;
    endtask

    task automatic test_load_ext();
        present(6'b100000, 32'h0000_301c, 5'd3, 32'h0, 32'h13, 32'h0);
        total++;
        if (WDW !== 32'hFFFF_FFAB) begin
            $display("FAIL lb WDW got %h want ffffffab", WDW);
        end else passed++;
        present(6'b100100, 32'h0000_3020, 5'd3, 32'h0, 32'h13, 32'h0);
        total++;
        if (WDW !== 32'h0000_00AB) begin
            $display("FAIL lbu WDW got %h want 000000ab", WDW);
        end else passed++;
        present(6'b100001, 32'h0000_3024, 5'd3, 32'h0, 32'h10, 32'h0);
        total++;
        if (WDW !== 32'hFFFF_BEEF) begin
            $display("FAIL lh WDW got %h want ffffbeef", WDW);
        end else passed++;
        present(6'b100101, 32'h0000_3028, 5'd3, 32'h0, 32'h12, 32'h0);
        total++;
        if (WDW !== 32'h0000_AB34) begin
            $display("FAIL lhu WDW got %h want 0000ab34", WDW);
        end else passed++;
    endtask

    task automatic test_passthrough();
        present(6'b000000, 32'h0000_302c, 5'd5, 32'd7, 32'h10, 32'hFFFF_FFFF);
        total++;
        if (WDW !== 32'd7 || A3W !== 5'd5) begin
            $display("FAIL addu got wd=%h a3=%h want 7 5", WDW, A3W);
        end else passed++;
        total++;
        if (InstrW !== 32'h0012_3456 || PCW !== 32'h0000_302c) begin
            $display("FAIL addu_regs got in=%h pc=%h want 00123456 0000302c",
                     InstrW, PCW);
        end else passed++;
        present(6'b100011, 32'h0000_3030, 5'd1, 32'h0, 32'h10, 32'h0);
        total++;
        if (WDW !== 32'hAB34_BEEF) begin
            $display("FAIL mem_untouched got %h want ab34beef", WDW);
        end else passed++;
    endtask

    task automatic test_reset_store();
        reset = 1'b1;
        present(6'b101011, 32'h0000_3034, 5'd0, 32'h0, 32'h20, 32'h9999_9999);
        total++;
        if (WDW !== 32'h0 || PCW !== 32'h0) begin
            $display("FAIL reset_hold got wd=%h pc=%h want 0", WDW, PCW);
        end else passed++;
        reset = 1'b0;
        present(6'b100011, 32'h0000_3038, 5'd1, 32'h1, 32'h20, 32'h0);
        total++;
        if (WDW !== 32'h0) begin
            $display("FAIL reset_store_suppressed got %h want 00000000", WDW);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        present(6'b101011, 32'h0000_4000, 5'd0, 32'h0, 32'h16, 32'h1122_3344);
        present(6'b101001, 32'h0000_4004, 5'd0, 32'h0, 32'h15, 32'hFFFF_5566);
        present(6'b100001, 32'h0000_4008, 5'd6, 32'h0, 32'h17, 32'h0);
        total++;
        if (WDW !== 32'h0000_1122) begin
            $display("FAIL lh_hi_misaligned got %h want 00001122", WDW);
        end else passed++;
        present(6'b100011, 32'h0000_400c, 5'd7, 32'h0, 32'h17, 32'h0);
        total++;
        if (WDW !== 32'h1122_5566) begin
            $display("FAIL lw_misaligned got %h want 11225566", WDW);
        end else passed++;
        present(6'b100000, 32'h0000_4010, 5'd8, 32'h0, 32'h14, 32'h0);
        total++;
        if (WDW !== 32'h0000_0066) begin
            $display("FAIL lb_lane0 got %h want 00000066", WDW);
        end else passed++;
        present(6'b100001, 32'h0000_4014, 5'd8, 32'h0, 32'h16, 32'h0);
        total++;
        if (WDW !== 32'h0000_1122) begin
            $display("FAIL lh_pos got %h want 00001122", WDW);
        end else passed++;
    endtask

    initial begin
        reset  = 1'b1;
        PCM    = '0;
        InstrM = '0;
        A3M    = '0;
        WDM    = '0;
        ResM   = '0;
        RD2M   = '0;
        #1;
        total++;
        if (PCW !== 32'h0 || InstrW !== 32'h0 || A3W !== 5'h0 || WDW !== 32'h0) begin
            $display("FAIL init_reset got pc=%h in=%h a3=%h wd=%h want 0",
                     PCW, InstrW, A3W, WDW);
        end else passed++;
        @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_store_load_word();
        test_byte_half_merge();
        test_load_ext();
        test_passthrough();
        test_reset_store();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM stage plus MEM/WB pipeline register; consumes what the EX/MEM register presents each cycle (PC, instruction, destination register, register write data, ALU result, store data). Holds the 16 KiB word-organised data memory, performs byte/half/word stores and sign/zero-extended loads, and registers the final write-back bundle for the W stage. A per-store write log for the course bench can be compiled in.

## Interface
Parameters:
- `DM_WORDS`, 4096: data memory depth in 32-bit words; address bits `[log2(DM_WORDS)+1:2]` of `ResM` are used.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears the pipeline register immediately.
- `PCM`  in  32  PC of the instruction in MEM.
- `InstrM`  in  32  instruction in MEM; 0 means bubble.
- `A3M`  in  5  destination register; 0 means no write.
- `WDM`  in  32  register write data for non-load instructions (ALU result, PC+8, ...).
- `ResM`  in  32  ALU result; the byte address for loads/stores.
- `RD2M`  in  32  store data (already forwarded).
- `PCW`  out  32  registered `PCM`.
- `InstrW`  out  32  registered `InstrM`.
- `A3W`  out  5  registered `A3M`.
- `WDW`  out  32  registered final write data: extended load value for loads, else `WDM`.

## Operation
- Decode `InstrM[31:26]`: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100, sw 101011, sh 101001, sb 101000; anything else is a non-memory instruction.
- Word index = `ResM[13:2]`; byte lane = `ResM[1:0]`. Misaligned bits are ignored: sw/lw use lane 0 regardless, sh/lh/lhu use `ResM[1]` only.
- Stores, byte enables: sw 1111; sh 0011 (`ResM[1]`=0) or 1100; sb a single bit at lane `ResM[1:0]`. Store data is replicated: sh puts `RD2M[15:0]` in both halves, sb puts `RD2M[7:0]` in all four bytes. Only enabled bytes change; the others keep their old value.
- Loads: combinational read of the addressed word, lane selection, then extension. lb/lh sign-extend; lbu/lhu zero-extend; lw takes the whole word.
- `WDW` next = load value if load, else `WDM`. `PCW`/`InstrW`/`A3W` copy their inputs.
- The memory array is not cleared by `reset`; it is zero at time 0.

## Timing
- Reset value of every output: `PCW`=0, `InstrW`=0, `A3W`=0, `WDW`=0. Outputs are forced to these values while `reset` is high, independent of `clk`.
- Load latency: the result is visible on `WDW` one edge after the load is presented in MEM.
- A store commits on the rising edge that ends its MEM cycle. A load of the same word in the next cycle returns the new data.
- A store and a load of the same word in the same cycle is impossible: one instruction per stage.
- `reset` high at an edge suppresses the store in MEM that cycle. A reset that deasserts mid-cycle takes effect from the next edge.
- The pipeline register has no stall or enable input: it loads every edge. Bubbles are `InstrM`=0, which decodes as sll and therefore writes nothing to memory.

## Configuration
- `DM_WRITE_LOG_EN` defined: on every committed store, the block `$display`s `@%h: *%h <= %h` with `PCM`, the word-aligned address (`ResM & 32'hfffffffc`, upper bits kept), and the full merged word. No log line when a store is suppressed by reset.
- Macro undefined: no display logic. Functional behaviour is identical.

## Structure
- Shared package `cpu_pkg`: opcode constants (`OP_LW` … `OP_SB`), a `mem_op_t` enum (NONE, LW, LH, LHU, LB, LBU, SW, SH, SB), and `DM_WORDS_DEFAULT`.
- One sub-module, `data_mem`: the word array with a 4-bit byte-enable synchronous write and an asynchronous read. Decode, lane logic, extension and the MEM/WB register live in `mem_wb_stage`.

## Test plan
- Reset: pulse `reset` between edges → all outputs are 0 immediately.
- Store word, then load word: sw `RD2M`=32'h12345678 at `ResM`=0x10 → log `*00000010 <= 12345678`; the next cycle lw 0x10 → `WDW`=32'h12345678 after one edge.
- Byte/half store merging: after the word above, sb 0xAB at 0x13 → word 32'hAB345678; sh 0xBEEF at 0x10 → 32'hAB34BEEF.
- Load extension on word 32'hAB34BEEF at 0x10: lb 0x13 → FFFFFFAB; lbu 0x13 → 000000AB; lh 0x10 → FFFFBEEF; lhu 0x12 → 0000AB34.
- Non-memory pass-through: addu with `WDM`=7, `A3M`=5 → `WDW`=7, `A3W`=5, memory unchanged.
- Reset at a store edge: sw to 0x20 with `reset` high → memory at 0x20 stays 0, no log line.
